// File: rtl/fp29i_pkg.sv
// Shared FP29i field layout and FP16 packing constants for the FIR output stage.
package fp29i_pkg;

  localparam int S_W = 1;
  localparam int E_W = 6;
  localparam int M_W = 22;

  localparam int          FP16_BIAS    = 15;
  localparam int          FP16_EXP_MAX = 31;
  localparam logic [14:0] FP16_INF     = 15'h7C00;

  typedef struct packed {
    logic [S_W-1:0] s;
    logic [E_W-1:0] e;
    logic [M_W-1:0] m;
  } fp29i_t;

endpackage

// File: rtl/fir_out_fp16_pack_lzc22.sv
// Combinational leading-zero counter for the 22-bit FP29i mantissa; returns 22 for zero.
module lzc22
  import fp29i_pkg::*;
(
  input  logic [M_W-1:0] m,
  output logic [4:0]     lz
);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    lz = 5'd22;
    for (int i = 0; i < M_W; i++) begin
      if (m[i]) lz = 5'(M_W - 1 - i);
    end
  end

endmodule

// File: rtl/fir_out_fp16_pack.sv
// Converts FIR FP29i results to IEEE FP16 (RNE, flush-to-zero) and queues them
// behind a valid/ready output FIFO.
module fir_out_fp16_pack
  import fp29i_pkg::*;
#(
  parameter int EXP_BIAS   = 30,
  parameter int MAN_FRAC   = 20,
  parameter int FIFO_DEPTH = 4   // power of 2, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [28:0] din_29i,
  input  logic        valid_in,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        overrun
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE = (PTR_W + 1)'(1);
  localparam logic signed [7:0] EXP_OFS = 8'(FP16_BIAS - EXP_BIAS - MAN_FRAC);

  // P0: capture on the rising edge of valid_in
  logic   valid_d_reg;
  logic   p0_valid_reg;
  fp29i_t p0_reg;
  logic   capture;

  assign capture = valid_in & ~valid_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d_reg  <= 1'b1;
      p0_valid_reg <= 1'b0;
      p0_reg       <= '0;
    end else begin
      valid_d_reg  <= valid_in;
      p0_valid_reg <= capture;
      if (capture) p0_reg <= din_29i;
    end
  end

  // P1: leading-zero count
  logic [4:0] lz_next;
  fp29i_t     p1_reg;
  logic [4:0] p1_lz_reg;
  logic       p1_valid_reg;

  lzc22 u_lzc (
    .m  (p0_reg.m),
    .lz (lz_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_reg       <= '0;
      p1_lz_reg    <= '0;
      p1_valid_reg <= 1'b0;
    end else begin
      p1_reg       <= p0_reg;
      p1_lz_reg    <= lz_next;
      p1_valid_reg <= p0_valid_reg;
    end
  end

  // P2: normalise; the leading one is implicit so only the 21 bits below it are kept
  logic [4:0]        p_next;
  logic [7:0]        exp_next;
  logic [20:0]       frac_next;
  logic              p2_s_reg;
  logic              p2_zero_reg;
  logic signed [7:0] p2_exp_reg;
  logic [20:0]       p2_frac_reg;
  logic              p2_valid_reg;

  assign p_next    = 5'(M_W - 1) - p1_lz_reg;
  assign exp_next  = {2'b00, p1_reg.e} + {3'b000, p_next} + EXP_OFS;
  assign frac_next = 21'(p1_reg.m << p1_lz_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_s_reg     <= 1'b0;
      p2_zero_reg  <= 1'b0;
      p2_exp_reg   <= '0;
      p2_frac_reg  <= '0;
      p2_valid_reg <= 1'b0;
    end else begin
      p2_s_reg     <= p1_reg.s;
      p2_zero_reg  <= (p1_lz_reg == 5'd22);
      p2_exp_reg   <= exp_next;
      p2_frac_reg  <= frac_next;
      p2_valid_reg <= p1_valid_reg;
    end
  end

  // P3: round-to-nearest-even and pack {unf, ovf, fp16}
  logic              g_bit, s_bit, inc;
  logic [10:0]       frac_sum;
  logic signed [7:0] exp_rnd;
  logic [17:0]       res_word;

  assign g_bit    = p2_frac_reg[10];
  assign s_bit    = |p2_frac_reg[9:0];
  assign inc      = g_bit & (s_bit | p2_frac_reg[11]);
  assign frac_sum = {1'b0, p2_frac_reg[20:11]} + {10'b0, inc};
  assign exp_rnd  = p2_exp_reg + {7'b0, frac_sum[10]};

  always_comb begin
    res_word = {2'b00, p2_s_reg, 15'h0};
    if (!p2_zero_reg) begin
      if (exp_rnd >= FP16_EXP_MAX)
        res_word = {2'b01, p2_s_reg, FP16_INF};
      else if (exp_rnd <= 0)
        res_word = {2'b10, p2_s_reg, 15'h0};
      else
        res_word = {2'b00, p2_s_reg, exp_rnd[4:0], frac_sum[9:0]};
    end
  end

  // Output FIFO; pointers carry an extra wrap bit to tell full from empty
  logic [PTR_W:0]                 wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W-1:0]               wr_idx, rd_idx;
  logic [FIFO_DEPTH-1:0][17:0]    mem_rd;
  logic                           empty, full, pop, push, drop;
  logic [17:0]                    head;

  assign wr_idx = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx = rd_ptr_reg[PTR_W-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) && (wr_idx == rd_idx);
  assign pop    = ~empty & dout_ready;
  assign push   = p2_valid_reg & (~full | pop);
  assign drop   = p2_valid_reg & full & ~pop;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
    logic [17:0] entry_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        entry_reg <= '0;
      else if (push && wr_idx == PTR_W'(gi))
        entry_reg <= res_word;
    end
    assign mem_rd[gi] = entry_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (drop) overrun    <= 1'b1;
    end
  end

  assign head       = mem_rd[rd_idx];
  assign dout       = head[15:0];
  assign flag_ovf   = head[16];
  assign flag_unf   = head[17];
  assign dout_valid = ~empty;

endmodule

// File: tb/tb_fir_out_fp16_pack.sv
// Scoreboard bench for fir_out_fp16_pack: directed corner cases plus random FP29i values.
module tb_fir_out_fp16_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [28:0] din_29i = '0;
  logic        valid_in = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        flag_ovf, flag_unf, overrun;

  int          total = 0;
  int          bad = 0;
  logic [17:0] exp_q[$];
  int          ready_mode = 0;   // 0 hold low, 1 hold high, 2 random (high every other clk), 3 one-shot
  int          ncyc = 0;

  always #5 clk = ~clk;

  fir_out_fp16_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_29i    (din_29i),
    .valid_in   (valid_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .flag_ovf   (flag_ovf),
    .flag_unf   (flag_unf),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [28:0] mk(input logic s, input int e, input longint m);
    return {s, 6'(e), 22'(m)};
  endfunction

  // Reference: value arithmetic on the leading-one position, remainder-vs-half rounding.
  function automatic logic [17:0] model(input logic [28:0] d);
    logic   s;
    int     e, p, sh, ex;
    longint m, f, q, rem, half;
    s = d[28];
    e = int'(d[27:22]);
    m = longint'(d[21:0]);
    if (m == 0) return {2'b00, s, 15'h0};
    p = 0;
    for (int i = 0; i < 22; i++) if (d[i]) p = i;
    ex = e + p - 30 - 20 + 15;
    f  = m - (longint'(1) << p);
    if (p >= 10) begin
      sh  = p - 10;
      q   = f >> sh;
      rem = f - (q << sh);
      if (sh > 0) begin
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
      end
    end else begin
      q = f << (10 - p);
    end
    if (q == 1024) begin
      q = 0;
      ex++;
    end
    if (ex >= 31) return {2'b01, s, 15'h7C00};
    if (ex <= 0)  return {2'b10, s, 15'h0};
    return {2'b00, s, 5'(ex), 10'(q)};
  endfunction

  // Sole driver of dout_ready
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      case (ready_mode)
        0: dout_ready = 1'b0;
        1: dout_ready = 1'b1;
        2: dout_ready = ncyc[0] ? 1'b1 : 1'($urandom_range(0, 1));
        default: begin
          dout_ready = 1'b1;
          ready_mode = 0;
        end
      endcase
    end
  end

  // Monitor: an entry is accepted at the next posedge when valid and ready are both high
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h expected none", {flag_unf, flag_ovf, dout});
        end else begin
          e = exp_q.pop_front();
          $display("pop: got %h expected %h", {flag_unf, flag_ovf, dout}, e);
          check("dout_word", {14'b0, flag_unf, flag_ovf, dout}, {14'b0, e});
        end
      end
    end
  end

  task automatic pulse(input logic [28:0] d, input bit push, input logic [17:0] e);
    @(negedge clk);
    din_29i  = d;
    valid_in = 1'b1;
    if (push) exp_q.push_back(e);
    $display("send: din=%h", d);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic set_ready(input int m);
    @(posedge clk);
    #1;
    ready_mode = m;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !dout_valid) done = 1'b1;
    end
    check(name, {31'b0, done}, 32'd1);
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [28:0] dv[8];
    logic [17:0] ev[8];
    logic [28:0] d;
    logic [28:0] fe;

    // Reset with valid_in held high through release
    valid_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_ovf", 32'(flag_ovf), 32'h0);
    check("rst_unf", 32'(flag_unf), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_capture_after_rst", 32'(dout_valid), 32'h0);
    valid_in = 1'b0;

    // Latency: write lands on the 3rd edge after capture
    set_ready(1);
    @(negedge clk);
    din_29i  = mk(1'b0, 30, 64'd1 << 20);
    valid_in = 1'b1;
    exp_q.push_back(18'h03C00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) valid_in = 1'b0;
      check($sformatf("latency_low_%0d", k), 32'(dout_valid), 32'h0);
    end
    @(negedge clk);
    check("latency_high", 32'(dout_valid), 32'h1);
    wait_drain("drain_latency");

    // Directed values, ties, overflow, underflow, rounding carry
    dv[0] = mk(1'b0, 30, 64'd3 << 19);                             ev[0] = 18'h03E00;
    dv[1] = mk(1'b1, 30, 64'd0);                                   ev[1] = 18'h08000;
    dv[2] = mk(1'b0, 30, (64'd1 << 20) | (64'd1 << 9));            ev[2] = 18'h03C00;
    dv[3] = mk(1'b0, 30, (64'd1 << 20) | (64'd1 << 10) | (64'd1 << 9)); ev[3] = 18'h03C02;
    dv[4] = mk(1'b0, 30, (64'd1 << 20) | (64'd1 << 9) | 64'd1);    ev[4] = 18'h03C01;
    dv[5] = mk(1'b0, 63, 64'd1 << 21);                             ev[5] = 18'h17C00;
    dv[6] = mk(1'b1, 0, 64'd1 << 20);                              ev[6] = 18'h28000;
    dv[7] = mk(1'b0, 44, 64'h3FFFFF);                              ev[7] = 18'h17C00;
    for (int i = 0; i < 8; i++) pulse(dv[i], 1'b1, ev[i]);
    wait_drain("drain_directed");

    // FIFO: fill to 4, simultaneous pop+write at full, then a dropped write
    set_ready(0);
    for (int i = 0; i < 4; i++) begin
      d = mk(1'b0, 30, (64'd1 << 20) | (64'(i + 1) << 12));
      pulse(d, 1'b1, model(d));
    end
    fe = mk(1'b0, 31, (64'd1 << 20) | (64'd5 << 12));
    @(negedge clk);
    din_29i  = fe;
    valid_in = 1'b1;
    exp_q.push_back(model(fe));
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    ready_mode = 3;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("overrun_simul_pop", 32'(overrun), 32'h0);
    d = mk(1'b0, 32, 64'd1 << 20);
    pulse(d, 1'b0, 18'h0);
    repeat (5) @(negedge clk);
    check("overrun_set", 32'(overrun), 32'h1);
    check("full_valid", 32'(dout_valid), 32'h1);
    set_ready(1);
    wait_drain("drain_fifo");
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Reset with two results in flight
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    din_29i  = mk(1'b0, 30, 64'd1 << 20);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    din_29i  = mk(1'b1, 30, 64'd1 << 20);
    valid_in = 1'b1;
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    check("inflight_rst_valid", 32'(dout_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("inflight_no_output", 32'(dout_valid), 32'h0);

    // Random values with a back-pressured consumer
    set_ready(2);
    for (int n = 0; n < 200; n++) begin
      logic s;
      int   e;
      longint m;
      s = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(20, 50));
      m = ($urandom_range(0, 15) == 0) ? 64'd0 :
          longint'(($urandom & 32'h3FFFFF) >> $urandom_range(0, 21));
      d = mk(s, e, m);
      pulse(d, 1'b1, model(d));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("drain_random");
    check("random_no_overrun", 32'(overrun), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
